// File: rtl/n_bit_divider.sv
// rtl/n_bit_divider.sv - radix-2 restoring unsigned divider, one quotient bit per clock
// Optional feature macro: DIVIDER_DBZ_CHECK_EN (early divide-by-zero completion with dbz flag)
module n_bit_divider #(
  parameter int DIVIDEND = 16,
  parameter int DIVISOR  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DIVIDEND-1:0] dividend,
  input  logic [DIVISOR-1:0]  divisor,
  output logic                busy,
  output logic                done,
  output logic [DIVIDEND-1:0] quotient,
  output logic [DIVISOR-1:0]  remainder,
  output logic                dbz
);

  // Counter wide enough to hold DIVIDEND-1 even when DIVIDEND is 1.
  localparam int CW = $clog2(DIVIDEND + 1);

`ifdef DIVIDER_DBZ_CHECK_EN
  // ZERO is a one-cycle stand-in for RUN when the divisor is zero.
  typedef enum logic [1:0] {IDLE, RUN, ZERO} state_t;
`else
  typedef enum logic [0:0] {IDLE, RUN} state_t;
`endif

  state_t state, state_next;

  // shreg starts as the dividend; dividend bits leave at the top while
  // quotient bits enter at the bottom, so after DIVIDEND steps it is the quotient.
  logic [DIVIDEND-1:0] shreg, shreg_next;
  logic [DIVISOR-1:0]  dvsr;
  logic [DIVISOR:0]    part, part_next;
  logic [DIVISOR:0]    shifted;
  logic [DIVISOR:0]    diff;
  logic                fits;
  logic [CW-1:0]       cnt;
  logic                last;
  logic                accept;

  assign accept = (state == IDLE) && start;
  assign last   = (cnt == CW'(DIVIDEND - 1));
  assign busy   = (state != IDLE);

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted    = {part[DIVISOR-1:0], shreg[DIVIDEND-1]};
    diff       = shifted - {1'b0, dvsr};
    fits       = (shifted >= {1'b0, dvsr});
    part_next  = fits ? diff : shifted;
    shreg_next = (shreg << 1) | DIVIDEND'(fits);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; start is only looked at in IDLE, so requests while busy are dropped.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef DIVIDER_DBZ_CHECK_EN
          state_next = (divisor == '0) ? ZERO : RUN;
`else
          state_next = RUN;
`endif
        end
      end
      RUN: begin
        if (last) begin
          state_next = IDLE;
        end
      end
`ifdef DIVIDER_DBZ_CHECK_EN
      ZERO: state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  // Working registers: load on accept, iterate while running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      dvsr  <= '0;
      part  <= '0;
      cnt   <= '0;
    end else if (accept) begin
      shreg <= dividend;
      dvsr  <= divisor;
      part  <= '0;
      cnt   <= '0;
    end else if (state == RUN) begin
      shreg <= shreg_next;
      part  <= part_next;
      cnt   <= cnt + 1'b1;
    end
  end

  // Result registers only change at completion, so they hold steady mid-run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIVIDER_DBZ_CHECK_EN
      dbz       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if ((state == RUN) && last) begin
        done      <= 1'b1;
        quotient  <= shreg_next;
        remainder <= part_next[DIVISOR-1:0];
`ifdef DIVIDER_DBZ_CHECK_EN
        dbz       <= 1'b0;
`endif
      end
`ifdef DIVIDER_DBZ_CHECK_EN
      // Same values the full iteration would give for a zero divisor.
      if (state == ZERO) begin
        done      <= 1'b1;
        quotient  <= '1;
        remainder <= shreg[DIVISOR-1:0];
        dbz       <= 1'b1;
      end
`endif
    end
  end

`ifndef DIVIDER_DBZ_CHECK_EN
  assign dbz = 1'b0;
`endif

endmodule

// File: tb/tb_n_bit_divider.sv
// tb/tb_n_bit_divider.sv - self-checking bench for n_bit_divider (16/8 directed plus 6/3 sweep)
module tb_n_bit_divider;

`ifdef DIVIDER_DBZ_CHECK_EN
  localparam bit DBZ_EN = 1'b1;
`else
  localparam bit DBZ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy, done, dbz;
  logic [15:0] quotient;
  logic [7:0]  remainder;

  logic        s_start;
  logic [5:0]  s_dividend;
  logic [2:0]  s_divisor;
  logic        s_busy, s_done, s_dbz;
  logic [5:0]  s_quotient;
  logic [2:0]  s_remainder;

  n_bit_divider #(.DIVIDEND(16), .DIVISOR(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .dbz(dbz)
  );

  n_bit_divider #(.DIVIDEND(6), .DIVISOR(3)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .dividend(s_dividend), .divisor(s_divisor),
    .busy(s_busy), .done(s_done), .quotient(s_quotient), .remainder(s_remainder), .dbz(s_dbz)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       tag;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          acc        = 0;
  logic [15:0] last_q     = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input string tag, input logic [15:0] a, input logic [7:0] b);
    exp_t e;
    e.tag = tag;
    if (b == 8'd0) begin
      e.q   = 32'h0000_FFFF;
      e.r   = {24'd0, a[7:0]};
      e.z   = DBZ_EN;
      e.lat = DBZ_EN ? 1 : 16;
    end else begin
      e.q   = 32'(a / 16'(b));
      e.r   = 32'(a % 16'(b));
      e.z   = 1'b0;
      e.lat = 16;
    end
    return e;
  endfunction

  task automatic start_op(input string tag, input logic [15:0] a, input logic [7:0] b);
    int g = 0;
    @(negedge clk);
    while (busy && g < 50) begin
      @(negedge clk);
      g++;
    end
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    sb.push_back(model(tag, a, b));
    @(negedge clk);
    start = 1'b0;
    acc   = cyc;
    check({tag, "/busy_after_accept"}, 32'(busy), 32'd1);
  endtask

  task automatic wait_done();
    int   k = 0;
    exp_t e;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      check("done_timeout", 32'd0, 32'd1);
      return;
    end
    if (sb.size() == 0) begin
      check("scoreboard_empty_at_done", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({e.tag, "/latency"}, 32'(cyc - acc), 32'(e.lat));
    check({e.tag, "/quotient"}, 32'(quotient), e.q);
    check({e.tag, "/remainder"}, 32'(remainder), e.r);
    check({e.tag, "/dbz"}, 32'(dbz), 32'(e.z));
    check({e.tag, "/busy_at_done"}, 32'(busy), 32'd0);
    last_q = quotient;
  endtask

  task automatic count_done(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
  endtask

  initial begin
    int pulses;
    int g;
    logic [5:0] eq;
    logic [2:0] er;

    rst = 1'b1;
    start = 1'b0; dividend = '0; divisor = '0;
    s_start = 1'b0; s_dividend = '0; s_divisor = '0;
    repeat (3) @(negedge clk);
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/done", 32'(done), 32'd0);
    check("reset/quotient", 32'(quotient), 32'd0);
    check("reset/remainder", 32'(remainder), 32'd0);
    check("reset/dbz", 32'(dbz), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset/busy", 32'(busy), 32'd0);

    start_op("1000/7", 16'd1000, 8'd7);
    wait_done();
    count_done(3, pulses);
    check("1000/7/single_done", 32'(pulses), 32'd0);

    start_op("0x1234/0", 16'h1234, 8'd0);
    wait_done();

    start_op("65535/255", 16'd65535, 8'd255);
    wait_done();

    start_op("5/9", 16'd5, 8'd9);
    wait_done();

    start_op("65535/1", 16'd65535, 8'd1);
    wait_done();

    start_op("0/3", 16'd0, 8'd3);
    wait_done();

    // A second request while busy must be dropped; outputs hold meanwhile.
    start_op("busy_ignore_1000/7", 16'd1000, 8'd7);
    repeat (4) @(negedge clk);
    check("busy_ignore/quotient_held", 32'(quotient), 32'(last_q));
    start    = 1'b1;
    dividend = 16'd9;
    divisor  = 8'd3;
    @(negedge clk);
    start = 1'b0;
    check("busy_ignore/still_busy", 32'(busy), 32'd1);
    wait_done();
    count_done(20, pulses);
    check("busy_ignore/no_extra_done", 32'(pulses), 32'd0);

    // Reset mid-run aborts the division immediately.
    start_op("reset_mid_run", 16'd1000, 8'd7);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_reset/busy", 32'(busy), 32'd0);
    check("mid_reset/done", 32'(done), 32'd0);
    check("mid_reset/quotient", 32'(quotient), 32'd0);
    check("mid_reset/remainder", 32'(remainder), 32'd0);
    check("mid_reset/dbz", 32'(dbz), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    count_done(20, pulses);
    check("mid_reset/no_done", 32'(pulses), 32'd0);
    start_op("200/10", 16'd200, 8'd10);
    wait_done();

    // start held high: the next operation is accepted in the done cycle.
    @(negedge clk);
    start    = 1'b1;
    dividend = 16'd200;
    divisor  = 8'd10;
    sb.push_back(model("held_start_a", 16'd200, 8'd10));
    sb.push_back(model("held_start_b", 16'd200, 8'd10));
    @(negedge clk);
    acc = cyc;
    wait_done();
    @(negedge clk);
    acc   = cyc;
    start = 1'b0;
    check("held_start/busy_after_done_cycle", 32'(busy), 32'd1);
    check("held_start/done_one_cycle", 32'(done), 32'd0);
    wait_done();

    // Exhaustive sweep of the 6/3 instance, including divisor 0.
    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 8; b++) begin
        @(negedge clk);
        s_start    = 1'b1;
        s_dividend = 6'(a);
        s_divisor  = 3'(b);
        @(negedge clk);
        s_start = 1'b0;
        g = 0;
        while (!s_done && g < 20) begin
          @(negedge clk);
          g++;
        end
        if (b == 0) begin
          eq = 6'h3F;
          er = 3'(a);
        end else begin
          eq = 6'(a / b);
          er = 3'(a % b);
        end
        check($sformatf("sweep %0d/%0d q_r", a, b), {23'd0, s_done, s_quotient, s_remainder},
              {23'd0, 1'b1, eq, er});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/n_bit_divider.md
# n_bit_divider

Parameterised sequential unsigned integer divider: a DIVIDEND-bit dividend is divided by a DIVISOR-bit divisor, giving a DIVIDEND-bit quotient and a DIVISOR-bit remainder. It uses a radix-2 restoring algorithm and retires one quotient bit per clock. It is a shared arithmetic helper inside the FP/integer datapath, driven by a start/done handshake from its controller.

## Interface
Parameters:
- DIVIDEND, 16, dividend and quotient width in bits (≥1)
- DIVISOR, 8, divisor and remainder width in bits (1 ≤ DIVISOR ≤ DIVIDEND)

Ports:
- clk  input  1  rising-edge clock; the only clock in the block
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a division; sampled only while busy=0
- dividend  input  DIVIDEND  unsigned dividend, sampled on the accepting edge
- divisor  input  DIVISOR  unsigned divisor, sampled on the accepting edge
- busy  output  1  high while a division is in progress
- done  output  1  single-cycle pulse when results become valid
- quotient  output  DIVIDEND  floor(dividend/divisor)
- remainder  output  DIVISOR  dividend − quotient·divisor
- dbz  output  1  divide-by-zero flag for the last result

## Operation
- States: IDLE, RUN.
- IDLE: when start=1 at an edge, latch the operands, clear the partial remainder P (DIVISOR+1 bits), clear the bit counter and go to RUN.
- RUN: each edge processes one dividend bit, MSB first:
  - P ← {P[DIVISOR-1:0], next dividend bit}
  - if P ≥ {0,divisor}: P ← P − divisor and the quotient bit is 1; otherwise the quotient bit is 0
- After DIVIDEND iterations: quotient ← the collected bits, remainder ← P[DIVISOR-1:0], pulse done, return to IDLE.
- start while busy=1 is ignored. No queuing.
- Outputs hold their last result until the next completion or reset. They do not change mid-run.
- Divisor = 0 produces quotient = all ones and remainder = dividend[DIVISOR-1:0]. This is what the algorithm yields naturally.
- All arithmetic is unsigned. The result is exact for every operand pair with divisor ≠ 0.
- Reset (asynchronous, any time, including mid-run): state=IDLE; busy, done, quotient, remainder and dbz all 0. Any division in progress is aborted and no done is produced.

## Timing
- Let E0 be the edge that accepts start. The iterations run on edges E1..E(DIVIDEND).
- busy is high from after E0 until after E(DIVIDEND).
- done is high for exactly the one cycle following E(DIVIDEND). quotient and remainder are valid in that same cycle.
- Latency from the accepting edge to done is DIVIDEND cycles. Throughput is one division per DIVIDEND+1 cycles.
- start may be held high continuously. A new operation is then accepted in the cycle where done=1, because busy=0 in that cycle.

## Configuration
- Macro: DIVIDER_DBZ_CHECK_EN.
- Defined:
  - A divisor of 0 is detected on the accepting edge. The RUN state is skipped.
  - done pulses after E1 (1-cycle latency).
  - quotient = all ones, remainder = dividend[DIVISOR-1:0], dbz = 1.
  - dbz is cleared on the next completion that has a nonzero divisor.
- Undefined:
  - dbz is tied to 0.
  - A divisor of 0 runs the full DIVIDEND cycles and gives the same quotient and remainder values.

## Test plan
- dividend=1000, divisor=7 → after 16 cycles, done=1 with quotient=142, remainder=6, dbz=0.
- dividend=65535, divisor=255 → quotient=257, remainder=0. Also dividend=5, divisor=9 → quotient=0, remainder=5.
- dividend=0x1234, divisor=0 → quotient=0xFFFF, remainder=0x34.
  - With DIVIDER_DBZ_CHECK_EN: dbz=1 and done after 1 cycle.
  - Without it: dbz=0 and done after 16 cycles.
- Start 1000/7, then pulse start with 9/3 at cycle 5 while busy → the second request is ignored and the result stays 142/6.
- Start 1000/7, assert rst at cycle 8 → all outputs 0 immediately and no done. A fresh 200/10 after release → quotient=20, remainder=0.
- Exhaustive sweep with DIVIDEND=6, DIVISOR=3 over all nonzero divisors → each quotient equals dividend/divisor and each remainder equals dividend mod divisor.
